// File: rtl/instr_fetch.sv
// instr_fetch: IF stage of the 5-stage MIPS pipeline; owns the PC and the IF/ID register
// and drives the I-cache read handshake, redirecting on branch/jump resolved in ID.
`timescale 1ns/1ps
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        rst_n,
   input  logic        Stall,
   output logic        ICACHE_ren,
   output logic [29:0] ICACHE_addr,
   input  logic [31:0] ICACHE_rdata,
   input  logic        ICACHE_stall,
   input  logic        Branch_result_ID,
   input  logic        Jump_ID,
   input  logic        JumptoReg_ID,
   input  logic [29:0] PC_Sign_extended_ID,
   input  logic [31:0] JumpReg_addr_ID,
   output logic [31:0] IR,
   output logic [31:0] PCtoReg_ID,
   output logic [31:0] PC_IF
);
   localparam logic [0:0] BOOT = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_pc4;
   logic        w_hold;
   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_next;
   assign w_hold     = Stall | ICACHE_stall;
   assign w_redirect = JumptoReg_ID | Jump_ID | Branch_result_ID;
   assign w_pc_next  = r_pc + 32'd4;
   // Targets are formed from the IF/ID registers, i.e. the instruction now in decode.
   assign w_target = JumptoReg_ID ? (JumpReg_addr_ID & ~32'h3) :
                     Jump_ID      ? {r_pc4[31:28], r_ir[25:0], 2'b00} :
                                    r_pc4 + {PC_Sign_extended_ID, 2'b00};
   assign ICACHE_ren  = (r_state == RUN);
   assign ICACHE_addr = r_pc[31:2];
   assign IR          = r_ir;
   assign PCtoReg_ID  = r_pc4;
   assign PC_IF       = r_pc;
   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= BOOT;
         r_pc    <= RESET_PC;
         r_ir    <= NOP;
         r_pc4   <= 32'd0;
      end else if (r_state == BOOT) begin
         r_state <= RUN;
      end else if (!w_hold) begin
         r_pc  <= w_redirect ? w_target : w_pc_next;
         r_ir  <= w_redirect ? NOP : ICACHE_rdata;
         r_pc4 <= w_redirect ? 32'd0 : w_pc_next;
      end
   end
endmodule
